alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream issue/write-back stage for the 8-bit, 4-bit-opcode ALU. Accepts one register-to-register or register-immediate operation per valid/ready handshake and reads operands from a local 8x8 register file. It drives ctrl/x/y into the combinational ALU, captures out/carry, and presents the result downstream with valid/ready. The result is written back to the register file on the downstream handshake.

Parameters:
DATA_W, 8, datapath width; must match the ALU operand width.
AW, 3, register address width (2^AW registers).
ZERO_R0, 1, 1 = r0 reads as 0 and ignores writes; 0 = r0 is an ordinary register.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  sequencer can accept an instruction
in_ctrl  in  4  ALU opcode, passed through unchanged
in_rd  in  AW  destination register
in_rs  in  AW  source register for ALU x
in_rt  in  AW  source register for ALU y (when in_imm_en=0)
in_imm_en  in  1  1 = ALU y takes in_imm
in_imm  in  DATA_W  immediate operand
alu_ctrl  out  4  to ALU ctrl
alu_x  out  DATA_W  to ALU x
alu_y  out  DATA_W  to ALU y
alu_out  in  DATA_W  from ALU out
alu_carry  in  1  from ALU carry
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  DATA_W  captured ALU out
res_carry  out  1  captured ALU carry
res_rd  out  AW  destination of the result
res_illegal  out  1  opcode was greater than 4'b1100
dbg_addr  in  AW  debug read address
dbg_data  out  DATA_W  combinational read of reg[dbg_addr]; r0 reads 0 when ZERO_R0=1
op_cnt  out  16  completed-operation count, wraps at 16'hFFFF

Behaviour:
- Reset (rst=1 at a clk edge, from any state):
  - FSM goes to IDLE; all registers, op_cnt, and the alu_ctrl/alu_x/alu_y latches clear to 0.
  - res_valid=0, res_data=0, res_carry=0, res_rd=0, res_illegal=0; in_ready=1 after reset.
  - An in-flight operation is discarded with no write-back and no op_cnt increment.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid & in_ready at edge N:
    - latch alu_ctrl <= in_ctrl, alu_x <= reg[in_rs], alu_y <= (in_imm_en ? in_imm : reg[in_rt]), rd;
    - go to EXEC.
  - EXEC (cycle N+1): in_ready=0; the ALU evaluates combinationally from the latched outputs. At edge N+1:
    - res_data <= alu_out, res_carry <= alu_carry, res_rd <= rd;
    - res_illegal <= (alu_ctrl > 4'b1100);
    - go to WB.
  - WB: res_valid=1 from cycle N+2; res_* stay stable while res_ready=0; in_ready=0. At the edge where res_valid & res_ready:
    - reg[res_rd] <= res_data, except rd=0 when ZERO_R0=1;
    - op_cnt increments; go to IDLE; res_valid drops the next cycle.
- Latency: accept to res_valid is 2 cycles. Minimum issue interval is 3 cycles; the next instruction can be accepted one cycle after the WB handshake.
- No hazards: write-back completes before the next accept, so a dependent instruction reads the updated value.
- alu_ctrl/alu_x/alu_y hold their last values outside EXEC; the ALU is combinational, so only the EXEC-cycle sample matters.
- Illegal opcodes (4'b1101..4'b1111) are passed through. The ALU returns 0/0, the result is written back as 0, and res_illegal=1.
- in_valid while not in IDLE is ignored (not consumed); the instruction must be held until in_ready.
- Same rd, rs, rt all allowed (e.g. r3 = r3 + r3).
- Registers have no reset-independent write path; only WB writes.

Test Plan:
- Reset: hold rst for 2 cycles -> in_ready=1, res_valid=0, op_cnt=0, dbg_data=0 for all dbg_addr 0..7.
- Add, imm = 8'h7F: ctrl=4'b0000, rd=1, rs=0, imm_en=1 -> res_valid exactly 2 cycles after accept, res_data=8'h7F, res_carry=0; after handshake dbg reg1=8'h7F, op_cnt=1.
- Carry, imm = 8'h81: ctrl=0000, rd=2, rs=1, imm_en=1 -> res_data=8'h00, res_carry=1, reg2=0.
- Register-register dependency: ctrl=4'b0101 (XOR), rd=3, rs=1, rt=1 issued right after the prior WB -> res_data=8'h00 using the updated reg1.
- Back-pressure and r0: res_ready=0 for 4 cycles -> res_* stable, in_ready=0, reg unchanged until the handshake. An op with rd=0, result 8'h55 -> res_data=8'h55, r0 stays 0.
- Illegal opcode and reset mid-op:
  - ctrl=4'b1111 -> res_data=0, res_carry=0, res_illegal=1.
  - rst asserted in EXEC of an op with rd=4 -> state IDLE, reg4=0, op_cnt unchanged from before that op.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue/write-back sequencer for the 8-bit ALU: reads operands from a local register file,
// drives the combinational ALU, captures its result and writes it back on the downstream handshake.
module alu_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int AW      = 3,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic [AW-1:0]     res_rd,
    output logic              res_illegal,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       op_cnt
);
    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [3:0]          ctrl_q;
    logic [DATA_W-1:0]   x_q, y_q;
    logic [AW-1:0]       rd_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_carry_q;
    logic [AW-1:0]       res_rd_q;
    logic                res_ill_q;
    logic [15:0]         op_cnt_q;
    logic                accept, wb_fire, wb_we;

    // r0 is hard-wired to zero when ZERO_R0 is set
    function automatic logic [DATA_W-1:0] read_reg(input logic [AW-1:0] a);
        if (ZERO_R0 && a == '0) return '0;
        return rf_q[a];
    endfunction

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        wb_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    wb_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_we = wb_fire && !(ZERO_R0 && res_rd_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_rd_q    <= '0;
            res_ill_q   <= 1'b0;
            op_cnt_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ctrl_q <= in_ctrl;
                x_q    <= read_reg(in_rs);
                y_q    <= in_imm_en ? in_imm : read_reg(in_rt);
                rd_q   <= in_rd;
            end
            // The ALU is combinational; its output is valid during EXEC only
            if (state_q == EXEC) begin
                res_data_q  <= alu_out;
                res_carry_q <= alu_carry;
                res_rd_q    <= rd_q;
                res_ill_q   <= (ctrl_q > 4'b1100);
            end
            if (wb_fire) op_cnt_q <= op_cnt_q + 16'd1;
            if (wb_we) rf_q[res_rd_q] <= res_data_q;
        end
    end

    assign alu_ctrl    = ctrl_q;
    assign alu_x       = x_q;
    assign alu_y       = y_q;
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_ill_q;
    assign op_cnt      = op_cnt_q;
    assign dbg_data    = read_reg(dbg_addr);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: randomized and directed instructions against a
// register-file reference model, with an ALU model closing the loop.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ctrl;
    logic [2:0] in_rd, in_rs, in_rt;
    logic       in_imm_en;
    logic [7:0] in_imm;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic       alu_carry;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic [2:0] res_rd;
    logic       res_illegal;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [15:0] op_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rr_rand = 1'b0;
    bit prev_v = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic [2:0] rd;
        logic       ill;
        int         acc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model_rf [8];
    logic [15:0] model_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer #(.DATA_W(8), .AW(3), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_rd(res_rd), .res_illegal(res_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .op_cnt(op_cnt)
    );

    // Environment ALU: {carry, out}; opcodes above 12 return 0/0
    function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'd0:  return {1'b0, x} + {1'b0, y};
            4'd1:  return {1'b0, x} - {1'b0, y};
            4'd2:  return {1'b0, x & y};
            4'd3:  return {1'b0, x | y};
            4'd4:  return {1'b0, ~(x & y)};
            4'd5:  return {1'b0, x ^ y};
            4'd6:  return {x, 1'b0};
            4'd7:  return {x[0], 1'b0, x[7:1]};
            4'd8:  return {1'b0, x} + 9'd1;
            4'd9:  return {1'b0, x} - 9'd1;
            4'd10: return {1'b0, x};
            4'd11: return {1'b0, y};
            4'd12: return {1'b0, ~(x | y)};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

    always @(posedge clk) begin
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(exp));
    endtask

    function automatic logic [7:0] mread(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : model_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_rf[i] = 8'h00;
        model_cnt = 16'd0;
    endtask

    // Wait for in_ready with in_valid held; returns the accept cycle
    task automatic drive_accept(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs,
                                input logic [2:0] rt, input logic ie, input logic [7:0] imm,
                                output int acc);
        int n;
        @(negedge clk);
        in_ctrl = c; in_rd = rd; in_rs = rs; in_rt = rt; in_imm_en = ie; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout got 0 want 1");
            $fatal(1, "accept timeout");
        end
        acc = cyc;
    endtask

    task automatic issue(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic ie, input logic [7:0] imm);
        exp_t e;
        logic [8:0] r;
        int acc;
        drive_accept(c, rd, rs, rt, ie, imm, acc);
        r = alu_f(c, mread(rs), ie ? imm : mread(rt));
        e.data = r[7:0]; e.carry = r[8]; e.rd = rd; e.ill = (c > 4'd12); e.acc = acc;
        sb.push_back(e);
        if (rd != 3'd0) model_rf[rd] = r[7:0];
        model_cnt = model_cnt + 16'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size() == 0 && in_ready), 32'd1);
    endtask

    // Monitor: compares every valid cycle against the head, pops on handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    if (!prev_v) chk("latency", 32'(cyc), 32'(sb[0].acc + 2));
                    chk("res_data", 32'(res_data), 32'(sb[0].data));
                    chk("res_carry", 32'(res_carry), 32'(sb[0].carry));
                    chk("res_rd", 32'(res_rd), 32'(sb[0].rd));
                    chk("res_illegal", 32'(res_illegal), 32'(sb[0].ill));
                    chk("in_ready_wb", 32'(in_ready), 32'd0);
                    if (res_ready) void'(sb.pop_front());
                end
            end
            prev_v = res_valid;
        end
    end

    initial begin
        int acc;
        logic [7:0] old5;
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_rd = '0; in_rs = '0; in_rt = '0;
        in_imm_en = 1'b0; in_imm = '0; res_ready = 1'b1; dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);
        for (int i = 0; i < 8; i++) dbg_chk(3'(i), 8'h00);

        // Reset while the op targeting r4 is in EXEC
        drive_accept(4'd0, 3'd4, 3'd0, 3'd0, 1'b1, 8'h33, acc);
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_op_cnt", 32'(op_cnt), 32'd0);
        dbg_chk(3'd4, 8'h00);
        repeat (3) @(negedge clk);
        chk("midrst_no_wb", 32'(res_valid), 32'd0);

        issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F);
        wait_idle();
        dbg_chk(3'd1, 8'h7F);
        chk("op_cnt_1", 32'(op_cnt), 32'd1);

        issue(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h81);
        issue(4'd5, 3'd3, 3'd1, 3'd1, 1'b0, 8'h00);
        wait_idle();
        dbg_chk(3'd2, 8'h00);
        dbg_chk(3'd3, 8'h00);

        // Back-pressure on an op writing r5
        @(posedge clk);
        #1 res_ready = 1'b0;
        old5 = mread(3'd5);
        issue(4'd0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h02);
        for (int n = 0; n < 10 && !res_valid; n++) @(negedge clk);
        chk("bp_valid", 32'(res_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            dbg_chk(3'd5, old5);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle();
        dbg_chk(3'd5, 8'h81);

        issue(4'd3, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55);
        wait_idle();
        dbg_chk(3'd0, 8'h00);

        issue(4'd0, 3'd6, 3'd1, 3'd0, 1'b1, 8'h01);
        issue(4'd15, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
        wait_idle();
        dbg_chk(3'd6, 8'h00);
        chk("op_cnt_dir", 32'(op_cnt), 32'(model_cnt));

        rr_rand = 1'b1;
        for (int i = 0; i < 80; i++)
            issue(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 8'($urandom));
        @(posedge clk);
        #1 rr_rand = 1'b0; res_ready = 1'b1;
        wait_idle();
        for (int i = 0; i < 8; i++) dbg_chk(3'(i), mread(3'(i)));
        chk("op_cnt_final", 32'(op_cnt), 32'(model_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
